// File: rtl/spi_flash_resp_pkg.sv
// Shared opcodes and responder state encoding for the SPI flash responder model.
package spi_flash_pkg;

    localparam logic [7:0] OP_WREN   = 8'h06;
    localparam logic [7:0] OP_WRDI   = 8'h04;
    localparam logic [7:0] OP_RDSR   = 8'h05;
    localparam logic [7:0] OP_CE     = 8'hC7;
    localparam logic [7:0] OP_CE_ALT = 8'h60;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        RDSR_OUT,
        IGNORE
    } resp_state_t;

    function automatic logic is_erase(input logic [7:0] op);
        return (op == OP_CE) || (op == OP_CE_ALT);
    endfunction

endpackage

// File: rtl/spi_flash_resp_if.sv
// Single-lane SPI pin bundle between an initiator (master) and the flash model (slave).
interface spi_flash_resp_if;

    logic CS;
    logic CLOCK;
    logic IO0;
    logic IO1;
    logic io1_oe;

    modport master (output CS, CLOCK, IO0, input IO1, io1_oe);
    modport slave  (input CS, CLOCK, IO0, output IO1, io1_oe);

endinterface

// File: rtl/spi_flash_resp_edge_det.sv
// Pin synchroniser and edge detector for SPI mode-0 test models: one register stage on
// CS/SCK/MOSI, plus a second stage on CS and SCK to form single-cycle edge pulses.
module spi_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic cs,
    input  logic sck,
    input  logic mosi,
    output logic cs_q,
    output logic mosi_q,
    output logic rise,
    output logic fall,
    output logic cs_rise,
    output logic cs_fall
);

    logic cs_qq;
    logic sck_q;
    logic sck_qq;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_q   <= 1'b1;
            cs_qq  <= 1'b1;
            sck_q  <= 1'b0;
            sck_qq <= 1'b0;
            mosi_q <= 1'b0;
        end else begin
            cs_q   <= cs;
            cs_qq  <= cs_q;
            sck_q  <= sck;
            sck_qq <= sck_q;
            mosi_q <= mosi;
        end
    end

    assign rise    =  sck_q & ~sck_qq;
    assign fall    = ~sck_q &  sck_qq;
    assign cs_rise =  cs_q  & ~cs_qq;
    assign cs_fall = ~cs_q  &  cs_qq;

endmodule

// File: rtl/spi_flash_resp.sv
// Cycle-accurate SPI flash responder: decodes WREN/WRDI/RDSR/chip-erase on a mode-0 link
// and models a programmable erase busy time on the WIP status bit.
module spi_flash_resp
    import spi_flash_pkg::*;
#(
    parameter int ERASE_CYCLES = 64,
    parameter int CMD_W        = 8
) (
    input  logic             ACLK,
    input  logic             ARESET,
    spi_flash_resp_if.slave  spi,
    output logic             wip,
    output logic             wel,
    output logic             erase_done,
    output logic [CMD_W-1:0] last_opcode
);

    localparam int         CNT_W    = (ERASE_CYCLES > 1) ? $clog2(ERASE_CYCLES) : 1;
    localparam logic [3:0] LAST_BIT = 4'(CMD_W - 1);
    localparam logic [3:0] FULL_CNT = 4'(CMD_W);

    logic             cs_q, mosi_q, rise, fall, cs_rise, cs_fall;
    resp_state_t      state, state_n;
    logic [3:0]       bit_cnt;
    logic [CMD_W-1:0] shift, shift_in;
    logic [7:0]       status, tx_reg;
    logic [2:0]       tx_idx;
    logic             io1_r, io1_oe_w, exec;
    logic [CNT_W-1:0] busy_cnt;

    spi_edge_det u_edge (
        .clk     (ACLK),
        .rst     (ARESET),
        .cs      (spi.CS),
        .sck     (spi.CLOCK),
        .mosi    (spi.IO0),
        .cs_q    (cs_q),
        .mosi_q  (mosi_q),
        .rise    (rise),
        .fall    (fall),
        .cs_rise (cs_rise),
        .cs_fall (cs_fall)
    );

    assign status   = {6'b0, wel, wip};
    assign shift_in = {shift[CMD_W-2:0], mosi_q};
    // Commands act only on a clean CS release with a whole opcode, and never while busy.
    assign exec     = cs_rise && (state != IDLE) && (bit_cnt == FULL_CNT) && !wip;

    always_ff @(posedge ACLK) begin
        if (ARESET) state <= IDLE;
        else        state <= state_n;
    end

    // NOTE: state_n gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_n = state;
        if (cs_rise) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE:     if (cs_fall) state_n = CMD;
                CMD:      if (rise && bit_cnt == LAST_BIT)
                              state_n = (shift_in == OP_RDSR) ? RDSR_OUT : IGNORE;
                default:  state_n = state;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            bit_cnt     <= '0;
            shift       <= '0;
            last_opcode <= '0;
            tx_reg      <= '0;
            tx_idx      <= '0;
            io1_r       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (cs_fall) begin
                    bit_cnt <= '0;
                    shift   <= '0;
                    io1_r   <= 1'b0;
                end
                CMD: if (rise) begin
                    shift   <= shift_in;
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == LAST_BIT) begin
                        last_opcode <= shift_in;
                        tx_reg      <= status;
                        tx_idx      <= 3'd7;
                    end
                end
                RDSR_OUT: if (fall) begin
                    io1_r <= tx_reg[tx_idx];
                    // Reload at the end of each byte so polling sees WIP/WEL change.
                    if (tx_idx == 3'd0) begin
                        tx_reg <= status;
                        tx_idx <= 3'd7;
                    end else begin
                        tx_idx <= tx_idx - 3'd1;
                    end
                end
                IGNORE: if (rise && bit_cnt != 4'hF) bit_cnt <= bit_cnt + 4'd1;
                default: ;
            endcase
        end
    end

    // Expiry is checked before command execution, so it wins a same-cycle cs_rise.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wip        <= 1'b0;
            wel        <= 1'b0;
            erase_done <= 1'b0;
            busy_cnt   <= '0;
        end else begin
            erase_done <= 1'b0;
            if (wip) begin
                if (busy_cnt == '0) begin
                    wip        <= 1'b0;
                    wel        <= 1'b0;
                    erase_done <= 1'b1;
                end else begin
                    busy_cnt <= busy_cnt - CNT_W'(1);
                end
            end else if (exec) begin
                if (shift == OP_WREN) begin
                    wel <= 1'b1;
                end else if (shift == OP_WRDI) begin
                    wel <= 1'b0;
                end else if (is_erase(shift) && wel) begin
                    wip      <= 1'b1;
                    busy_cnt <= CNT_W'(ERASE_CYCLES - 1);
                end
            end
        end
    end

    assign io1_oe_w   = (state == RDSR_OUT) && !cs_q;
    assign spi.io1_oe = io1_oe_w;
    assign spi.IO1    = io1_oe_w & io1_r;

endmodule

// File: tb/tb_spi_flash_resp.sv
// Self-checking bench for spi_flash_resp: directed scenarios plus a randomized command mix
// compared against a transaction-level status model.
module tb_spi_flash_resp;
    import spi_flash_pkg::*;

    localparam int EC   = 64;
    localparam int HALF = 2;

    logic       ACLK   = 1'b0;
    logic       ARESET = 1'b1;
    logic       wip, wel, erase_done;
    logic [7:0] last_opcode;

    int total = 0;
    int bad   = 0;

    // Transaction-level device model
    logic       m_wip  = 1'b0;
    logic       m_wel  = 1'b0;
    logic [7:0] m_last = 8'h00;
    int         erase_base = 0;

    // Erase monitor
    int   done_cnt = 0;
    int   run      = 0;
    int   done_run = 0;
    logic done_wip = 1'b0;

    logic [7:0] rd_q[$];

    spi_flash_resp_if spi ();

    spi_flash_resp #(.ERASE_CYCLES(EC), .CMD_W(8)) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .spi         (spi),
        .wip         (wip),
        .wel         (wel),
        .erase_done  (erase_done),
        .last_opcode (last_opcode)
    );

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) begin
        #1;
        if (erase_done) begin
            done_cnt++;
            done_run = run;
            done_wip = wip;
        end
        run = wip ? run + 1 : 0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge ACLK);
    endtask

    function automatic bit known(input logic [7:0] op);
        return op inside {OP_WREN, OP_WRDI, OP_RDSR, OP_CE, OP_CE_ALT};
    endfunction

    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx, output int oe_n);
        logic [7:0] sh;
        sh   = tx;
        rx   = 8'h00;
        oe_n = 0;
        for (int i = 0; i < nbits; i++) begin
            spi.IO0 = sh[7];
            sh      = sh << 1;
            tick(HALF);
            if (i < 8) rx = {rx[6:0], spi.IO1};
            if (spi.io1_oe) oe_n++;
            spi.CLOCK = 1'b1;
            tick(HALF);
            spi.CLOCK = 1'b0;
        end
    endtask

    task automatic cs_low;
        spi.CS = 1'b0;
        tick(2);
    endtask

    task automatic cs_high;
        tick(HALF);
        spi.CS = 1'b1;
        tick(2);
    endtask

    task automatic command(input logic [7:0] op, input int nbits);
        logic [7:0] rx;
        int         oe;
        cs_low();
        xfer(op, nbits, rx, oe);
        cs_high();
        if (nbits >= 8) m_last = op;
        if (nbits == 8 && !m_wip) begin
            if (op == OP_WREN) m_wel = 1'b1;
            else if (op == OP_WRDI) m_wel = 1'b0;
            else if ((op == OP_CE || op == OP_CE_ALT) && m_wel) begin
                m_wip      = 1'b1;
                erase_base = done_cnt;
            end
        end
        check($sformatf("wip op=%02h n=%0d", op, nbits), wip, m_wip);
        check($sformatf("wel op=%02h n=%0d", op, nbits), wel, m_wel);
        check($sformatf("last_opcode op=%02h n=%0d", op, nbits), last_opcode, m_last);
    endtask

    task automatic rdsr(input int nbytes);
        logic [7:0] rx;
        int         oe;
        rd_q.delete();
        cs_low();
        xfer(OP_RDSR, 8, rx, oe);
        check("oe_cmd_phase", oe, 0);
        for (int b = 0; b < nbytes; b++) begin
            xfer(8'h00, 8, rx, oe);
            rd_q.push_back(rx);
            check("oe_data_phase", oe, 8);
        end
        cs_high();
        m_last = OP_RDSR;
        check("oe_after_cs", spi.io1_oe, 0);
        check("io1_idle", spi.IO1, 0);
    endtask

    task automatic finish_erase;
        for (int i = 0; i < 4 * EC && done_cnt == erase_base; i++) tick(1);
        tick(1);
        check("erase_done_pulses", done_cnt, erase_base + 1);
        check("wip_high_cycles", done_run, EC);
        check("done_with_wip_low", done_wip, 0);
        m_wip = 1'b0;
        m_wel = 1'b0;
        check("wip_after_erase", wip, m_wip);
        check("wel_after_erase", wel, m_wel);
    endtask

    initial begin
        int         k, nb, seq_err, base;
        logic [7:0] op;

        spi.CS    = 1'b1;
        spi.CLOCK = 1'b0;
        spi.IO0   = 1'b0;
        tick(3);
        check("rst_io1", spi.IO1, 0);
        check("rst_oe", spi.io1_oe, 0);
        check("rst_wip", wip, 0);
        check("rst_wel", wel, 0);
        check("rst_erase_done", erase_done, 0);
        check("rst_last_opcode", last_opcode, 8'h00);
        ARESET = 1'b0;
        tick(2);

        rdsr(1);
        check("rdsr_after_reset", rd_q[0], 8'h00);

        command(OP_WREN, 8);
        rdsr(1);
        check("rdsr_wel", rd_q[0], 8'h02);
        command(OP_WRDI, 8);
        rdsr(1);
        check("rdsr_wrdi", rd_q[0], 8'h00);

        // Erase while polling continuously
        command(OP_WREN, 8);
        command(OP_CE, 8);
        rdsr(80);
        check("poll_first_byte", rd_q[0], 8'h03);
        check("poll_last_byte", rd_q[79], 8'h00);
        seq_err = 0;
        for (int b = 0; b < 80; b++) begin
            if (!(rd_q[b] == 8'h03 || rd_q[b] == 8'h00)) seq_err++;
            if (b > 0 && rd_q[b] == 8'h03 && rd_q[b-1] == 8'h00) seq_err++;
        end
        check("poll_sequence", seq_err, 0);
        finish_erase();

        // Erase refused without WEL, and on a truncated or overlong opcode
        command(OP_CE, 8);
        command(OP_WREN, 8);
        command(OP_CE, 5);
        command(OP_CE_ALT, 9);
        command(OP_WRDI, 8);

        // WRDI and WREN are ignored while busy
        command(OP_WREN, 8);
        command(OP_CE_ALT, 8);
        command(OP_WRDI, 8);
        finish_erase();
        command(OP_WREN, 8);
        command(OP_CE, 8);
        command(OP_WREN, 8);
        finish_erase();

        // Randomized command mix
        for (int it = 0; it < 40; it++) begin
            k  = $urandom_range(0, 6);
            nb = 8;
            case (k)
                0, 6: op = OP_WREN;
                1:    op = OP_WRDI;
                2:    op = ($urandom_range(0, 1) != 0) ? OP_CE : OP_CE_ALT;
                3: begin
                    op = 8'($urandom);
                    while (known(op)) op = 8'($urandom);
                end
                4: begin
                    op = ($urandom_range(0, 1) != 0) ? OP_WREN : OP_CE;
                    nb = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 7) : $urandom_range(9, 11);
                end
                default: op = OP_RDSR;
            endcase
            command(op, nb);
            if (m_wip) finish_erase();
            rdsr(1);
            check($sformatf("rand_rdsr it=%0d", it), rd_q[0], {6'b0, m_wel, m_wip});
        end

        // Reset in the middle of an erase
        command(OP_WREN, 8);
        command(OP_CE, 8);
        tick(10);
        ARESET = 1'b1;
        tick(1);
        check("midrst_wip", wip, 0);
        check("midrst_wel", wel, 0);
        check("midrst_erase_done", erase_done, 0);
        check("midrst_last_opcode", last_opcode, 8'h00);
        tick(2);
        ARESET = 1'b0;
        m_wip  = 1'b0;
        m_wel  = 1'b0;
        m_last = 8'h00;
        base   = done_cnt;
        tick(2 * EC);
        check("midrst_no_done", done_cnt, base);
        rdsr(1);
        check("midrst_rdsr", rd_q[0], 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
